// File: rtl/mem_data_assembler_if.sv
// rtl/mem_data_assembler_if.sv - load-side handshake bundle between the controller and mem_data_assembler
interface mem_data_assembler_if #(
  parameter int DATA_W = 32,
  parameter int BUS_W  = 8
);
  logic              start;
  logic [1:0]        size;
  logic              sign_ext;
  logic [BUS_W-1:0]  mem_data;
  logic              mem_valid;
  logic [DATA_W-1:0] data_out;
  logic              done;
  logic              busy;

  modport master (
    output start, size, sign_ext, mem_data, mem_valid,
    input  data_out, done, busy
  );

  modport slave (
    input  start, size, sign_ext, mem_data, mem_valid,
    output data_out, done, busy
  );
endinterface

// File: rtl/mem_data_assembler.sv
// rtl/mem_data_assembler.sv - multi-beat little-endian load assembler with zero/sign extension
// Optional feature macro: MEMD_SIGN_EXT_EN (honour sign_ext; otherwise results are zero-extended)
module mem_data_assembler #(
  parameter int DATA_W = 32,
  parameter int BUS_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_data_assembler_if.slave   bus
);
  localparam int CNT_W = $clog2(DATA_W / 8) + 1;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t            r_state;
  logic [1:0]        r_size;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_asm;
  logic [DATA_W-1:0] r_data_out;
  logic              r_done;
  logic              r_busy;

  logic [6:0]        w_abits;
  logic [CNT_W-1:0]  w_nbeats;
  logic              w_last;
  logic [7:0]        w_shift;
  logic [DATA_W-1:0] w_beat;
  logic [DATA_W-1:0] w_merged;
  logic [DATA_W-1:0] w_mask;
  logic              w_sign_bit;
  logic              w_sign;
  logic [DATA_W-1:0] w_result;

`ifdef MEMD_SIGN_EXT_EN
  logic r_sign;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sign <= 1'b0;
    end else if (r_state == IDLE && bus.start) begin
      r_sign <= bus.sign_ext;
    end
  end
  assign w_sign = r_sign;
`else
  logic w_unused_sign_ext;
  assign w_unused_sign_ext = bus.sign_ext;
  assign w_sign            = 1'b0;
`endif

  always_comb begin
    w_abits = 7'd8;
    case (r_size)
      2'b00:   w_abits = 7'd8;
      2'b01:   w_abits = 7'd16;
      2'b10:   w_abits = 7'd32;
      default: w_abits = (DATA_W == 64) ? 7'd64 : 7'd32;
    endcase
  end

  // Bus wider than the access still takes exactly one beat.
  always_comb begin
    w_nbeats = CNT_W'(1);
    if (w_abits >= 7'(BUS_W)) begin
      w_nbeats = CNT_W'(w_abits / 7'(BUS_W));
    end
  end

  assign w_last   = (r_cnt == (w_nbeats - CNT_W'(1)));
  assign w_shift  = 8'(r_cnt) * 8'(BUS_W);
  assign w_beat   = DATA_W'(bus.mem_data) << w_shift;
  assign w_merged = r_asm | w_beat;

  // Shifting out of range yields 0, so A == DATA_W gives an all-ones mask.
  assign w_mask     = (DATA_W'(1) << w_abits) - DATA_W'(1);
  assign w_sign_bit = |(w_merged & (w_mask ^ (w_mask >> 1)));
  assign w_result   = (w_merged & w_mask) | ((w_sign && w_sign_bit) ? ~w_mask : '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_size     <= 2'b00;
      r_cnt      <= '0;
      r_asm      <= '0;
      r_data_out <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_size  <= bus.size;
            r_cnt   <= '0;
            r_asm   <= '0;
            r_busy  <= 1'b1;
            r_state <= COLLECT;
          end
        end
        COLLECT: begin
          if (bus.mem_valid) begin
            r_asm <= w_merged;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_data_out <= w_result;
              r_done     <= 1'b1;
              r_busy     <= 1'b0;
              r_state    <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.data_out = r_data_out;
  assign bus.done     = r_done;
  assign bus.busy     = r_busy;
endmodule
